// File: rtl/prbs7_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_frame_ctrl
//  Description : Frames a 32-bit PRBS7 generator into test bursts: holds the
//                generator in reset, sends a SYNC_WORD preamble, then passes
//                frame_len generator words on a registered, qualified output.
//                Optional macro ERR_INJECT_EN adds single-bit error injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs7_frame_ctrl #(
  parameter int          RST_CYC   = 4,
  parameter int          PRE_WORDS = 8,
  parameter logic [31:0] SYNC_WORD = 32'hBC50_BC50,
  parameter int          LEN_W     = 16
) (
  input  logic             CLK,
  input  logic             rstA,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [31:0]      gen_data,
  output logic             gen_rstn,
  output logic [31:0]      data_out,
  output logic             data_valid,
  output logic             sync_flag,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] word_cnt,
  input  logic [4:0]       inj_bit,
  input  logic [LEN_W-1:0] inj_word
);

  // One counter serves both the generator-reset phase and the preamble phase.
  localparam int                CYC_MAX    = (RST_CYC > PRE_WORDS) ? RST_CYC : PRE_WORDS;
  localparam int                CYC_W      = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0]  c_rst_last = CYC_W'(RST_CYC - 1);
  localparam logic [CYC_W-1:0]  c_pre_last = CYC_W'(PRE_WORDS - 1);
  localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GRST = 3'd1,
    ST_PRE  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [CYC_W-1:0]   w_cyc_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_data;
  logic [31:0]        w_data_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_sync;
  logic               w_sync_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_gen_rstn;
  logic               w_gen_rstn_nxt;
  logic [31:0]        w_inj_mask;

`ifdef ERR_INJECT_EN
  logic [4:0]         r_inj_bit;
  logic [LEN_W-1:0]   r_inj_word;

  // Capture the injection target together with the burst length so that
  // mid-burst changes on the inj_* inputs have no effect.
  always_ff @(posedge CLK or negedge rstA) begin
    if (!rstA) begin
      r_inj_bit  <= '0;
      r_inj_word <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_inj_bit  <= inj_bit;
      r_inj_word <= inj_word;
    end
  end

  // Flip the selected bit only while loading the selected PRBS word; the
  // word index equals the count of words already issued.
  always_comb begin
    w_inj_mask = '0;
    if (r_cnt == r_inj_word) begin
      w_inj_mask[r_inj_bit] = 1'b1;
    end
  end
`else
  assign w_inj_mask = '0;
  wire w_unused_inj = ^{inj_bit, inj_word};
`endif

  // State register.
  always_ff @(posedge CLK or negedge rstA) begin
    if (!rstA) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next values of every registered output; the action taken
  // on an edge is decided by the state occupied during the preceding cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_sync_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_GRST;
          w_len_nxt   = frame_len;
          w_cnt_nxt   = '0;
          w_cyc_nxt   = '0;
        end
      end
      ST_GRST: begin
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else if (r_cyc == c_rst_last) begin
          w_state_nxt = ST_PRE;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt   = r_cyc + 1'b1;
        end
      end
      ST_PRE: begin
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_data_nxt  = SYNC_WORD;
          w_valid_nxt = 1'b1;
          w_sync_nxt  = 1'b1;
          if (r_cyc == c_pre_last) begin
            w_cyc_nxt   = '0;
            w_state_nxt = (r_len != '0) ? ST_RUN : ST_DONE;
          end else begin
            w_cyc_nxt   = r_cyc + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else begin
          // Generator output is combinational from its state, so the word
          // loaded here is the one present before this edge advances it.
          w_data_nxt  = gen_data ^ w_inj_mask;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + c_len_one;
          // Ending on len-1 -> len keeps an all-ones length from wrapping.
          if (r_cnt == r_len - c_len_one) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Generator runs only while in RUN; done flags the single DONE cycle.
  assign w_gen_rstn_nxt = (w_state_nxt == ST_RUN);
  assign w_done_nxt     = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  // Datapath and status registers.
  always_ff @(posedge CLK or negedge rstA) begin
    if (!rstA) begin
      r_cyc      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sync     <= 1'b0;
      r_done     <= 1'b0;
      r_gen_rstn <= 1'b0;
    end else begin
      r_cyc      <= w_cyc_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_sync     <= w_sync_nxt;
      r_done     <= w_done_nxt;
      r_gen_rstn <= w_gen_rstn_nxt;
    end
  end

  assign gen_rstn   = r_gen_rstn;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign sync_flag  = r_sync;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign word_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs7_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs7_frame_ctrl
//  Description : Directed self-checking bench for prbs7_frame_ctrl with a
//                behavioural 32-bit PRBS7 (x^7+x^6+1) generator attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs7_frame_ctrl;

  localparam logic [31:0] c_sync  = 32'hBC50_BC50;
  localparam logic [31:0] c_seedw = 32'hFE04_1851;

  logic        CLK;
  logic        rstA;
  logic        start;
  logic        stop;
  logic [15:0] frame_len;
  logic [31:0] gen_data;
  logic        gen_rstn;
  logic [31:0] data_out;
  logic        data_valid;
  logic        sync_flag;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;
  logic [4:0]  inj_bit;
  logic [15:0] inj_word;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_w [0:15];
  logic [6:0]  gen_st;

  prbs7_frame_ctrl dut (
    .CLK        (CLK),
    .rstA       (rstA),
    .start      (start),
    .stop       (stop),
    .frame_len  (frame_len),
    .gen_data   (gen_data),
    .gen_rstn   (gen_rstn),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sync_flag  (sync_flag),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt),
    .inj_bit    (inj_bit),
    .inj_word   (inj_word)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 39 sequence bits starting at the state: s[n] = s[n-6] ^ s[n-7].
  function automatic logic [38:0] prbs_seq(input logic [6:0] st);
    logic [38:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) s[i] = st[6-i];
    for (int i = 7; i < 39; i++) s[i] = s[i-6] ^ s[i-7];
    return s;
  endfunction

  function automatic logic [31:0] prbs_word(input logic [6:0] st);
    logic [38:0] s;
    logic [31:0] w;
    s = prbs_seq(st);
    for (int i = 0; i < 32; i++) w[31-i] = s[i];
    return w;
  endfunction

  function automatic logic [6:0] prbs_next(input logic [6:0] st);
    logic [38:0] s;
    logic [6:0]  n;
    s = prbs_seq(st);
    for (int k = 0; k < 7; k++) n[6-k] = s[32+k];
    return n;
  endfunction

  // Generator model: reseeds to all ones while gen_rstn is low.
  always @(posedge CLK or negedge gen_rstn) begin
    if (!gen_rstn) gen_st <= 7'h7F;
    else           gen_st <= prbs_next(gen_st);
  end
  assign gen_data = prbs_word(gen_st);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one burst; samples at negedge until the done pulse is seen.
  task automatic do_burst(input logic [15:0] len, input int stop_after, input bit poke,
                          input bit stop_with_start,
                          output int nsync, output int nword, output bit gen_hi);
    bit          seen_done;
    logic [31:0] ew;
    seen_done = 1'b0;
    nsync     = 0;
    nword     = 0;
    gen_hi    = 1'b0;
    @(negedge CLK);
    start     = 1'b1;
    stop      = stop_with_start;
    frame_len = len;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      if (gen_rstn) gen_hi = 1'b1;
      if (data_valid && sync_flag) begin
        check("sync_word", data_out, c_sync);
        nsync++;
      end else if (data_valid) begin
        ew = (nword < 16) ? exp_w[nword] : 32'h0;
`ifdef ERR_INJECT_EN
        if (nword == 0) ew = ew ^ 32'h1;
`endif
        check("prbs_word", data_out, ew);
        nword++;
      end
      if (done) seen_done = 1'b1;
      stop  = (stop_after != 0 && nword == stop_after && !seen_done);
      start = poke && (c == 3);
      if (poke && c == 3) frame_len = 16'd9;
      if (!seen_done) @(negedge CLK);
    end
    stop  = 1'b0;
    start = 1'b0;
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  int nsync, nword;
  bit gen_hi;
  logic [6:0] st;

  initial begin
    st = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = prbs_word(st);
      st       = prbs_next(st);
    end
    rstA      = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    frame_len = '0;
    inj_bit   = 5'd0;
    inj_word  = 16'd0;
    repeat (2) @(negedge CLK);
    check("rst_gen_rstn", {31'd0, gen_rstn}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_sync", {31'd0, sync_flag}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    rstA = 1'b1;

    // Burst of 4 with a start pulse and frame_len change while busy.
    check("seed_word_model", exp_w[0], c_seedw);
    do_burst(16'd4, 0, 1'b1, 1'b0, nsync, nword, gen_hi);
    check("b1_nsync", 32'(nsync), 32'd8);
    check("b1_nword", 32'(nword), 32'd4);
    check("b1_gen_hi", {31'd0, gen_hi}, 32'd1);
    check("b1_cnt_done", {16'd0, word_cnt}, 32'd4);
    @(negedge CLK);
    check("b1_idle_busy", {31'd0, busy}, 32'd0);
    check("b1_idle_valid", {31'd0, data_valid}, 32'd0);
    check("b1_idle_done", {31'd0, done}, 32'd0);
    check("b1_idle_gen", {31'd0, gen_rstn}, 32'd0);
    check("b1_cnt_hold", {16'd0, word_cnt}, 32'd4);

    // Same request again must give the identical burst.
    do_burst(16'd4, 0, 1'b0, 1'b0, nsync, nword, gen_hi);
    check("b2_nsync", 32'(nsync), 32'd8);
    check("b2_nword", 32'(nword), 32'd4);
    check("b2_cnt", {16'd0, word_cnt}, 32'd4);

    // Zero length: preamble only, generator never released.
    do_burst(16'd0, 0, 1'b0, 1'b0, nsync, nword, gen_hi);
    check("z_nsync", 32'(nsync), 32'd8);
    check("z_nword", 32'(nword), 32'd0);
    check("z_gen_hi", {31'd0, gen_hi}, 32'd0);
    check("z_cnt", {16'd0, word_cnt}, 32'd0);

    // Stop on the third RUN word of a 6-word burst.
    do_burst(16'd6, 2, 1'b0, 1'b0, nsync, nword, gen_hi);
    check("s_nword", 32'(nword), 32'd2);
    check("s_valid_done", {31'd0, data_valid}, 32'd0);
    check("s_cnt", {16'd0, word_cnt}, 32'd2);

    // Start and stop together from IDLE: start wins; len=1 boundary.
    do_burst(16'd1, 0, 1'b0, 1'b1, nsync, nword, gen_hi);
    check("ss_nsync", 32'(nsync), 32'd8);
    check("ss_nword", 32'(nword), 32'd1);
    check("ss_cnt", {16'd0, word_cnt}, 32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge CLK);
    start     = 1'b1;
    frame_len = 16'd10;
    @(negedge CLK);
    start = 1'b0;
    repeat (14) @(negedge CLK);
    check("ar_pre_busy", {31'd0, busy}, 32'd1);
    check("ar_pre_gen", {31'd0, gen_rstn}, 32'd1);
    #3 rstA = 1'b0;
    #1;
    check("ar_gen_rstn", {31'd0, gen_rstn}, 32'd0);
    check("ar_data_out", data_out, 32'd0);
    check("ar_valid", {31'd0, data_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_cnt", {16'd0, word_cnt}, 32'd0);
    @(negedge CLK);
    rstA = 1'b1;

    // After reset the generator is reseeded: burst starts from the seed word.
    do_burst(16'd2, 0, 1'b0, 1'b0, nsync, nword, gen_hi);
    check("pr_nword", 32'(nword), 32'd2);
    check("pr_cnt", {16'd0, word_cnt}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
